ram_upload: RTL

//  HPS upload responder: the read-back counterpart of the rominit download path.

---
 rtl/scv_pkg.sv | 8 +
 rtl/ram_upload.sv | 107 ++++++++++
 2 files changed

// File: rtl/scv_pkg.sv
// Shared types and constants for the scv core glue (HPS upload responder FSM).
package scv_pkg;

    typedef enum logic [1:0] {UPL_IDLE, UPL_REQ, UPL_HOLD} upl_state_t;

    localparam logic [7:0] UPL_IDX_CARTRAM = 8'd4;

endpackage

// File: rtl/ram_upload.sv
// HPS upload responder: serves ioctl upload reads from a byte RAM port and
// tracks whether battery RAM has been modified since the last complete upload.
module ram_upload
    import scv_pkg::*;
#(
    parameter logic [7:0] UPL_INDEX = UPL_IDX_CARTRAM,
    parameter int         AW        = 13,
    parameter logic [7:0] OOR_DATA  = 8'hFF
) (
    input  logic          CLK_SYS,
    input  logic          RESB,
    input  logic          IOCTL_UPLOAD,
    input  logic [7:0]    IOCTL_INDEX,
    input  logic          IOCTL_RD,
    input  logic [24:0]   IOCTL_ADDR,
    output logic [7:0]    IOCTL_DIN,
    output logic          IOCTL_WAIT,
    output logic          MEM_OWN,
    output logic          MEM_REQ,
    output logic [AW-1:0] MEM_ADDR,
    input  logic          MEM_ACK,
    input  logic [7:0]    MEM_DATA,
    input  logic          CPU_WR,
    output logic          SAVE_PENDING,
    output logic          UPL_DONE
);

    localparam logic [25:0] RAM_BYTES = 26'(1) << AW;
    localparam logic [AW:0] CNT_FULL  = {1'b1, {AW{1'b0}}};

    upl_state_t    state_q;
    logic [7:0]    din_q;
    logic          sel_q;
    logic          mem_req_q;
    logic [AW-1:0] mem_addr_q;
    logic [AW:0]   cnt_q;
    logic          pend_q;
    logic          done_q;

    logic sel, sel_fall, in_range, rd_ack;

    assign sel      = IOCTL_UPLOAD && (IOCTL_INDEX == UPL_INDEX);
    assign sel_fall = sel_q && !sel;
    assign in_range = {1'b0, IOCTL_ADDR} < RAM_BYTES;
    assign rd_ack   = (state_q == UPL_REQ) && MEM_ACK;

    always_ff @(posedge CLK_SYS or negedge RESB) begin
        if (!RESB) begin
            state_q    <= UPL_IDLE;
            din_q      <= 8'h00;
            sel_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sel_q  <= sel;
            done_q <= sel_fall;

            case (state_q)
                UPL_IDLE: begin
                    if (IOCTL_RD && sel) begin
                        if (in_range) begin
                            mem_addr_q <= IOCTL_ADDR[AW-1:0];
                            mem_req_q  <= 1'b1;
                            state_q    <= UPL_REQ;
                        end else begin
                            din_q   <= OOR_DATA;
                            state_q <= UPL_HOLD;
                        end
                    end
                end
                UPL_REQ: begin
                    // An aborted upload still completes the RAM handshake, but drops the byte.
                    if (MEM_ACK) begin
                        if (sel) din_q <= MEM_DATA;
                        mem_req_q <= 1'b0;
                        state_q   <= UPL_HOLD;
                    end
                end
                UPL_HOLD: state_q <= UPL_IDLE;
                default:  state_q <= UPL_IDLE;
            endcase

            if (sel_fall)
                cnt_q <= '0;
            else if (rd_ack && sel && (cnt_q != CNT_FULL))
                cnt_q <= cnt_q + 1'b1;

            // A CPU write racing the end of a full upload keeps the flag set.
            if (CPU_WR)
                pend_q <= 1'b1;
            else if (sel_fall && (cnt_q == CNT_FULL))
                pend_q <= 1'b0;
        end
    end

    assign IOCTL_WAIT   = sel && ((state_q != UPL_IDLE) || IOCTL_RD);
    assign IOCTL_DIN    = din_q;
    assign MEM_OWN      = sel_q;
    assign MEM_REQ      = mem_req_q;
    assign MEM_ADDR     = mem_addr_q;
    assign SAVE_PENDING = pend_q;
    assign UPL_DONE     = done_q;

endmodule
